// File: rtl/load_store_unit.sv
// Memory-access stage: req/ack data-memory transaction with byte lanes and load extension.
// Optional LSU_MISALIGN_TRAP_EN: misaligned half/word accesses return resp_err without a memory cycle.
module load_store_unit #(
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [2:0]            req_mode,
    input  logic [DATA_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    output logic                  resp_err,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [DATA_WIDTH-1:0] mem_addr,
    output logic [3:0]            mem_be,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_ack,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_e;

    state_e                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d, cnt_inc;
    logic [2:0]             mode_q, mode_d;
    logic [1:0]             lane_q, lane_d;
    logic                   mem_req_q, mem_req_d;
    logic                   mem_we_q, mem_we_d;
    logic [DATA_WIDTH-1:0]  mem_addr_q, mem_addr_d;
    logic [3:0]             mem_be_q, mem_be_d;
    logic [DATA_WIDTH-1:0]  mem_wdata_q, mem_wdata_d;
    logic                   resp_valid_q, resp_valid_d;
    logic                   resp_err_q, resp_err_d;
    logic [DATA_WIDTH-1:0]  resp_rdata_q, resp_rdata_d;

    logic                   legal, misal;
    logic [3:0]             be_req;
    logic [DATA_WIDTH-1:0]  wd_req;
    logic [7:0]             byte_v;
    logic [15:0]            half_v;
    logic [DATA_WIDTH-1:0]  load_ext;

    always_comb begin
        if (req_we) begin
            legal = req_mode inside {3'b000, 3'b001, 3'b010};
        end else begin
            legal = req_mode inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        end
        misal = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
        misal = (req_mode[1:0] == 2'b01 && req_addr[0]) ||
                (req_mode[1:0] == 2'b10 && req_addr[1:0] != 2'b00);
`endif
        case (req_mode[1:0])
            2'b00: begin
                be_req = 4'b0001 << req_addr[1:0];
                wd_req = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                be_req = 4'b0011 << {req_addr[1], 1'b0};
                wd_req = {2{req_wdata[15:0]}};
            end
            default: begin
                be_req = 4'b1111;
                wd_req = req_wdata;
            end
        endcase
    end

    // Lane selection ignores unaligned low bits (half uses a[1], word uses lane 0).
    always_comb begin
        case (lane_q)
            2'd0:    byte_v = mem_rdata[7:0];
            2'd1:    byte_v = mem_rdata[15:8];
            2'd2:    byte_v = mem_rdata[23:16];
            default: byte_v = mem_rdata[31:24];
        endcase
        half_v = lane_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (mode_q)
            3'b000:  load_ext = {{24{byte_v[7]}}, byte_v};
            3'b001:  load_ext = {{16{half_v[15]}}, half_v};
            3'b010:  load_ext = mem_rdata;
            3'b100:  load_ext = {24'd0, byte_v};
            3'b101:  load_ext = {16'd0, half_v};
            default: load_ext = '0;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        cnt_inc      = cnt_q + CW'(1);
        mode_d       = mode_q;
        lane_d       = lane_q;
        mem_req_d    = 1'b0;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_be_d     = mem_be_q;
        mem_wdata_d  = mem_wdata_q;
        resp_valid_d = 1'b0;
        resp_err_d   = 1'b0;
        resp_rdata_d = '0;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    mode_d = req_mode;
                    lane_d = req_addr[1:0];
                    if (!legal || misal) begin
                        state_d      = S_RESP;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                    end else begin
                        state_d     = S_ACCESS;
                        cnt_d       = '0;
                        mem_req_d   = 1'b1;
                        mem_we_d    = req_we;
                        mem_addr_d  = {req_addr[DATA_WIDTH-1:2], 2'b00};
                        mem_be_d    = be_req;
                        mem_wdata_d = wd_req;
                    end
                end
            end
            S_ACCESS: begin
                if (mem_ack) begin
                    state_d      = S_RESP;
                    resp_valid_d = 1'b1;
                    resp_rdata_d = mem_we_q ? '0 : load_ext;
                end else if (cnt_inc == CNT_MAX) begin
                    state_d      = S_RESP;
                    cnt_d        = cnt_inc;
                    resp_valid_d = 1'b1;
                    resp_err_d   = 1'b1;
                end else begin
                    cnt_d     = cnt_inc;
                    mem_req_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            mode_q       <= '0;
            lane_q       <= '0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_be_q     <= '0;
            mem_wdata_q  <= '0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            mode_q       <= mode_d;
            lane_q       <= lane_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_be_q     <= mem_be_d;
            mem_wdata_q  <= mem_wdata_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            resp_rdata_q <= resp_rdata_d;
        end
    end

    assign req_ready  = (state_q == S_IDLE);
    assign resp_valid = resp_valid_q;
    assign resp_err   = resp_err_q;
    assign resp_rdata = resp_rdata_q;
    assign mem_req    = mem_req_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_be     = mem_be_q;
    assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with hand-computed expectations.
// Build with LSU_MISALIGN_TRAP_EN to check the misalignment trap variant.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_mode;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_err;
    logic [31:0] resp_rdata;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    load_store_unit #(.DATA_WIDTH(32), .TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_mode(req_mode),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_err(resp_err),
        .resp_rdata(resp_rdata),
        .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One complete access; ack on the first ACCESS cycle when a memory cycle is expected.
    task automatic acc(input string tag, input logic we, input logic [2:0] mode,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input logic [31:0] rd, input logic exp_mem,
                       input logic [31:0] e_addr, input logic [3:0] e_be,
                       input logic [31:0] e_wd, input logic e_err,
                       input logic [31:0] e_rd);
        check({tag, ".ready"}, {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1;
        req_we    = we;
        req_mode  = mode;
        req_addr  = addr;
        req_wdata = wd;
        tick();
        req_valid = 1'b0;
        check({tag, ".busy"}, {31'd0, req_ready}, 32'd0);
        if (exp_mem) begin
            check({tag, ".mreq"}, {31'd0, mem_req}, 32'd1);
            check({tag, ".mwe"}, {31'd0, mem_we}, {31'd0, we});
            check({tag, ".maddr"}, mem_addr, e_addr);
            check({tag, ".mbe"}, {28'd0, mem_be}, {28'd0, e_be});
            if (we) check({tag, ".mwd"}, mem_wdata, e_wd);
            mem_ack   = 1'b1;
            mem_rdata = rd;
            tick();
            mem_ack   = 1'b0;
        end
        check({tag, ".rv"}, {31'd0, resp_valid}, 32'd1);
        check({tag, ".rerr"}, {31'd0, resp_err}, {31'd0, e_err});
        check({tag, ".rdata"}, resp_rdata, e_rd);
        check({tag, ".mreq_off"}, {31'd0, mem_req}, 32'd0);
        check({tag, ".rdy_off"}, {31'd0, req_ready}, 32'd0);
        tick();
        check({tag, ".rv_off"}, {31'd0, resp_valid}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_mode  = 3'b000;
        req_addr  = '0;
        req_wdata = '0;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        #12;
        check("rst.mreq", {31'd0, mem_req}, 32'd0);
        check("rst.rv", {31'd0, resp_valid}, 32'd0);
        check("rst.rdata", resp_rdata, 32'd0);
        check("rst.be", {28'd0, mem_be}, 32'd0);
        rst_n = 1'b1;
        tick();
        check("rst.ready", {31'd0, req_ready}, 32'd1);

        // Reset mid-access
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_mode  = 3'b010;
        req_addr  = 32'h100;
        tick();
        req_valid = 1'b0;
        check("mid.mreq", {31'd0, mem_req}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("mid.mreq_clr", {31'd0, mem_req}, 32'd0);
        check("mid.ready", {31'd0, req_ready}, 32'd1);
        check("mid.rv", {31'd0, resp_valid}, 32'd0);
        #10 rst_n = 1'b1;
        tick();
        check("mid.rv2", {31'd0, resp_valid}, 32'd0);
        tick();
        check("mid.rv3", {31'd0, resp_valid}, 32'd0);
        check("mid.ready2", {31'd0, req_ready}, 32'd1);

        acc("lb", 1'b0, 3'b000, 32'h203, 32'h0, 32'h80112233, 1'b1,
            32'h200, 4'b1000, 32'h0, 1'b0, 32'hFFFFFF80);
        acc("lbu", 1'b0, 3'b100, 32'h203, 32'h0, 32'h80112233, 1'b1,
            32'h200, 4'b1000, 32'h0, 1'b0, 32'h00000080);
        acc("sh", 1'b1, 3'b001, 32'h42, 32'hDEADBEEF, 32'h12345678, 1'b1,
            32'h40, 4'b1100, 32'hBEEFBEEF, 1'b0, 32'h0);
        acc("sb", 1'b1, 3'b000, 32'h11, 32'h123456A5, 32'h0, 1'b1,
            32'h10, 4'b0010, 32'hA5A5A5A5, 1'b0, 32'h0);
        acc("sw", 1'b1, 3'b010, 32'h24, 32'hCAFEF00D, 32'h0, 1'b1,
            32'h24, 4'b1111, 32'hCAFEF00D, 1'b0, 32'h0);
        acc("lh", 1'b0, 3'b001, 32'h2, 32'h0, 32'h80017FFF, 1'b1,
            32'h0, 4'b1100, 32'h0, 1'b0, 32'hFFFF8001);
        acc("lw", 1'b0, 3'b010, 32'h8, 32'h0, 32'h13579BDF, 1'b1,
            32'h8, 4'b1111, 32'h0, 1'b0, 32'h13579BDF);

        // Timeout with TIMEOUT_CYCLES=4; stray ack while idle must be ignored
        mem_ack = 1'b1;
        tick();
        check("stray.mreq", {31'd0, mem_req}, 32'd0);
        check("stray.rv", {31'd0, resp_valid}, 32'd0);
        mem_ack   = 1'b0;
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_mode  = 3'b010;
        req_addr  = 32'h300;
        tick();
        req_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("to.mreq%0d", i), {31'd0, mem_req}, 32'd1);
            check($sformatf("to.rv%0d", i), {31'd0, resp_valid}, 32'd0);
            tick();
        end
        check("to.mreq_off", {31'd0, mem_req}, 32'd0);
        check("to.rv", {31'd0, resp_valid}, 32'd1);
        check("to.err", {31'd0, resp_err}, 32'd1);
        check("to.rdata", resp_rdata, 32'd0);
        tick();
        check("to.rv_off", {31'd0, resp_valid}, 32'd0);
        acc("after_to", 1'b0, 3'b010, 32'h304, 32'h0, 32'h0BADCAFE, 1'b1,
            32'h304, 4'b1111, 32'h0, 1'b0, 32'h0BADCAFE);

        acc("ill_ld", 1'b0, 3'b011, 32'h0, 32'h0, 32'h0, 1'b0,
            32'h0, 4'b0000, 32'h0, 1'b1, 32'h0);
        acc("ill_st", 1'b1, 3'b100, 32'h0, 32'h0, 32'h0, 1'b0,
            32'h0, 4'b0000, 32'h0, 1'b1, 32'h0);
        acc("lhu_a", 1'b0, 3'b101, 32'h12, 32'h0, 32'h9ABC0000, 1'b1,
            32'h10, 4'b1100, 32'h0, 1'b0, 32'h00009ABC);
        acc("lhu_b", 1'b0, 3'b101, 32'h12, 32'h0, 32'h9ABC0000, 1'b1,
            32'h10, 4'b1100, 32'h0, 1'b0, 32'h00009ABC);

`ifdef LSU_MISALIGN_TRAP_EN
        acc("mis_lw", 1'b0, 3'b010, 32'h101, 32'h0, 32'h0, 1'b0,
            32'h0, 4'b0000, 32'h0, 1'b1, 32'h0);
        acc("mis_sh", 1'b1, 3'b001, 32'h43, 32'h1234, 32'h0, 1'b0,
            32'h0, 4'b0000, 32'h0, 1'b1, 32'h0);
`else
        acc("mis_lw", 1'b0, 3'b010, 32'h101, 32'h0, 32'h89ABCDEF, 1'b1,
            32'h100, 4'b1111, 32'h0, 1'b0, 32'h89ABCDEF);
        acc("mis_lh", 1'b0, 3'b001, 32'h43, 32'h0, 32'hF00D0123, 1'b1,
            32'h40, 4'b1100, 32'h0, 1'b0, 32'hFFFFF00D);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Memory-access stage downstream of the control decoder.
- Consumes MemWrite and AddressingControl (funct3) plus the ALU-computed address and rs2 data.
- Runs a req/ack transaction to the word-organised data memory, generating byte enables and lane-replicated write data.
- Returns sign/zero-extended load data to writeback and holds the pipeline via req_ready while busy.

Parameters:
- DATA_WIDTH, 32, data/address width; only 32 is supported.
- TIMEOUT_CYCLES, 255, maximum cycles mem_req is held without mem_ack before the access aborts; must be >= 1.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  execute stage presents an access.
- req_ready  out  1  unit can accept an access; high only in IDLE.
- req_we  in  1  1 = store (MemWrite), 0 = load.
- req_mode  in  3  AddressingControl/funct3. Loads: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu. Stores: 000 sb, 001 sh, 010 sw.
- req_addr  in  32  byte address (ALU result).
- req_wdata  in  32  store data (rs2).
- resp_valid  out  1  one-cycle completion pulse; issued for loads and stores.
- resp_err  out  1  qualifies resp_valid: illegal mode, timeout, or misalignment (optional feature).
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- mem_req  out  1  memory request, held until mem_ack.
- mem_we  out  1  memory write.
- mem_addr  out  32  word address {addr[31:2],2'b00}.
- mem_be  out  4  byte enables, lane 0 = bits 7:0.
- mem_wdata  out  32  lane-replicated store data.
- mem_ack  in  1  memory completion, sampled while mem_req=1.
- mem_rdata  in  32  read word, valid when mem_ack=1.

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE.
  - mem_req, mem_we, mem_be, mem_addr, mem_wdata, resp_valid, resp_err, resp_rdata and the timeout counter all go to 0.
  - Asserting reset mid-transaction drops mem_req immediately; no response is issued.
- States:
  - IDLE: req_ready=1. Accept on req_valid & req_ready, capturing we, mode, addr and wdata.
    - Legal mode (loads 000/001/010/100/101, stores 000/001/010) -> ACCESS.
    - Any other mode -> RESP with err=1, and no memory cycle.
  - ACCESS: mem_req=1 with mem_we/mem_addr/mem_be/mem_wdata stable.
    - Counter increments each cycle without mem_ack.
    - mem_ack=1 -> capture mem_rdata, go to RESP with err=0.
    - Counter reaches TIMEOUT_CYCLES with no ack -> drop mem_req, go to RESP with err=1.
    - Counter clears on ACCESS entry.
  - RESP: resp_valid=1 for exactly one cycle, then return to IDLE. There is no backpressure on the response.
- Latency: accept at cycle N, mem_req at N+1. If ack arrives at N+1, resp_valid is at N+2. Back-to-back throughput is one access per 3 cycles.
- req_ready is 0 in ACCESS and RESP. The pipeline stalls on req_valid & !req_ready.
- Byte enables, with a = addr[1:0]:
  - byte: 4'b0001 << a.
  - half: 4'b0011 << {a[1],1'b0}.
  - word: 4'b1111.
  - Loads use the same enables as stores.
- Write data:
  - sb: {4{wdata[7:0]}}.
  - sh: {2{wdata[15:0]}}.
  - sw: wdata.
- Load extraction from the lane selected by a:
  - lb/lh: sign-extend.
  - lbu/lhu: zero-extend.
  - lw: full word.
- Misaligned access (half with a[0]=1, word with a!=0): without the optional feature, the low address bits are ignored (half uses a[1], word uses lane 0) and the access proceeds normally.
- mem_ack outside ACCESS is ignored.
- req_valid outside IDLE is ignored; the upstream stage must hold it.

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- Defined: a misaligned half/word access goes IDLE -> RESP with resp_err=1 and resp_rdata=0. No mem_req is issued and no memory state changes.
- Undefined: the misalignment truncation rule above applies and no error is raised.

Test Plan:
- Reset mid-access:
  - Stimulus: accept lw at 0x100; pull rst_n low while mem_req=1.
  - Required: mem_req, resp_valid and req_ready-path state cleared asynchronously the same cycle; after release req_ready=1 and no resp_valid.
- Byte loads:
  - Stimulus: lb, addr 0x203, mem_rdata 0x80112233, ack on the first cycle.
  - Required: mem_addr 0x200, mem_be 1000, resp_rdata 0xFFFFFF80, resp_valid 2 cycles after accept.
  - Repeat as lbu: resp_rdata 0x00000080.
- Half store:
  - Stimulus: sh, addr 0x42, wdata 0xDEADBEEF.
  - Required: mem_we=1, mem_be 1100, mem_wdata 0xBEEFBEEF, mem_addr 0x40, resp_err=0, resp_rdata=0.
- Timeout:
  - Stimulus: TIMEOUT_CYCLES=4, lw, mem_ack held at 0.
  - Required: mem_req drops after 4 cycles; resp_valid=1 with resp_err=1 for one cycle; next access accepted normally.
- Illegal mode and back-to-back:
  - Stimulus: mode 011 load.
  - Required: no mem_req; resp_err=1 one cycle after accept.
  - Then: two consecutive lhu 0x12 with mem_rdata 0x9ABC0000.
  - Required: each returns 0x00009ABC; req_ready low between them.
- Misaligned word:
  - Stimulus: lw at 0x101.
  - Required with LSU_MISALIGN_TRAP_EN: no mem_req, resp_err=1.
  - Required without it: mem_addr 0x100, mem_be 1111, resp_err=0.
